nibble_serial_add_ctrl: RTL and testbench

- Sequencer that performs a wide signed/unsigned addition by stepping one 4-bit adder slice across NIBBLES nibbles, one nibble per clock.
- Keeps the inter-nibble carry in a register and computes overflow from the top nibble.
- Takes operands on a valid/ready request handshake and returns the result on a valid/ready response handshake.
- Fronts the 4-bit signed adder datapath so wide operands reuse a single slice.

---
 rtl/nibble_serial_add_ctrl_pkg.sv | 17 +
 rtl/nibble_serial_add_ctrl_if.sv | 41 ++++
 rtl/nibble_serial_add_ctrl_nibble_add_cin.sv | 25 ++
 rtl/nibble_serial_add_ctrl.sv | 115 +++++++++++
 tb/tb_nibble_serial_add_ctrl.sv | 216 +++++++++++++++++++++
 5 files changed

// File: rtl/nibble_serial_add_ctrl_pkg.sv
// rtl/nibble_serial_add_ctrl_pkg.sv - shared types, slice width and overflow rule for the nibble-serial adder
package nsac_pkg;

  localparam int SLICE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Signed overflow: operands agree in sign but the result sign differs.
  function automatic logic ov_rule(input logic a3, input logic b3, input logic s3);
    return (a3 == b3) && (s3 != a3);
  endfunction

endpackage

// File: rtl/nibble_serial_add_ctrl_if.sv
// rtl/nibble_serial_add_ctrl_if.sv - request/response bundle for the nibble-serial adder (optional NSAC_SUB_EN)
interface nibble_serial_add_ctrl_if #(
  parameter int NIBBLES = 4
);
  localparam int W = 4 * NIBBLES;

  logic         start_valid;
  logic         start_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
`ifdef NSAC_SUB_EN
  logic         sub;
`endif
  logic         res_valid;
  logic         res_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         ov;
  logic         busy;

`ifdef NSAC_SUB_EN
  modport master (
    output start_valid, a, b, sub, res_ready,
    input  start_ready, res_valid, sum, cout, ov, busy
  );
  modport slave (
    input  start_valid, a, b, sub, res_ready,
    output start_ready, res_valid, sum, cout, ov, busy
  );
`else
  modport master (
    output start_valid, a, b, res_ready,
    input  start_ready, res_valid, sum, cout, ov, busy
  );
  modport slave (
    input  start_valid, a, b, res_ready,
    output start_ready, res_valid, sum, cout, ov, busy
  );
`endif

endinterface

// File: rtl/nibble_serial_add_ctrl_nibble_add_cin.sv
// rtl/nibble_serial_add_ctrl_nibble_add_cin.sv - combinational 4-bit adder slice with carry-in
module nibble_add_cin
  import nsac_pkg::*;
(
  input  logic [SLICE_W-1:0] x,
  input  logic [SLICE_W-1:0] y,
  input  logic               cin,
  output logic [SLICE_W-1:0] s,
  output logic               c,
  output logic               x3,
  output logic               y3
);

  logic [SLICE_W:0] total;

  // Full 5-bit sum so the carry-out falls out of the top bit.
  always_comb begin
    total = {1'b0, x} + {1'b0, y} + {{SLICE_W{1'b0}}, cin};
    s     = total[SLICE_W-1:0];
    c     = total[SLICE_W];
    x3    = x[SLICE_W-1];
    y3    = y[SLICE_W-1];
  end

endmodule

// File: rtl/nibble_serial_add_ctrl.sv
// rtl/nibble_serial_add_ctrl.sv - sequencer stepping one 4-bit slice across NIBBLES nibbles (optional NSAC_SUB_EN)
module nibble_serial_add_ctrl #(
  parameter int NIBBLES = 4
) (
  input logic                     clk,
  input logic                     rst,
  nibble_serial_add_ctrl_if.slave bus
);
  import nsac_pkg::*;

  localparam int W     = SLICE_W * NIBBLES;
  localparam int IDX_W = $clog2(NIBBLES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

  state_t             state;
  state_t             state_next;
  logic [IDX_W-1:0]   idx;
  logic               carry;
  logic [W-1:0]       op_a;
  logic [W-1:0]       op_b;
  logic [W-1:0]       sum_r;
  logic               cout_r;
  logic               ov_r;

  logic [W-1:0]       b_in;
  logic               carry_init;
  logic               accept;
  logic               last;

  logic [SLICE_W-1:0] slice_s;
  logic               slice_c;
  logic               slice_x3;
  logic               slice_y3;

`ifdef NSAC_SUB_EN
  // Subtraction is A + ~B + 1: invert B on the way in and seed the carry.
  assign b_in       = bus.sub ? ~bus.b : bus.b;
  assign carry_init = bus.sub;
`else
  assign b_in       = bus.b;
  assign carry_init = 1'b0;
`endif

  assign accept = bus.start_valid && (state == IDLE);
  assign last   = (idx == LAST_IDX);

  nibble_add_cin u_slice (
    .x   (op_a[SLICE_W*idx +: SLICE_W]),
    .y   (op_b[SLICE_W*idx +: SLICE_W]),
    .cin (carry),
    .s   (slice_s),
    .c   (slice_c),
    .x3  (slice_x3),
    .y3  (slice_y3)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state: accept in IDLE, walk the nibbles in RUN, hold result in DONE.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bus.start_valid) state_next = RUN;
      RUN:     if (last)            state_next = DONE;
      DONE:    if (bus.res_ready)   state_next = IDLE;
      default:                      state_next = IDLE;
    endcase
  end

  // Datapath: operand latch on accept, one nibble per RUN cycle, flags on the top nibble.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx    <= '0;
      carry  <= 1'b0;
      op_a   <= '0;
      op_b   <= '0;
      sum_r  <= '0;
      cout_r <= 1'b0;
      ov_r   <= 1'b0;
    end else if (accept) begin
      op_a  <= bus.a;
      op_b  <= b_in;
      sum_r <= '0;
      carry <= carry_init;
      idx   <= '0;
    end else if (state == RUN) begin
      sum_r[SLICE_W*idx +: SLICE_W] <= slice_s;
      carry <= slice_c;
      if (last) begin
        cout_r <= slice_c;
        ov_r   <= ov_rule(slice_x3, slice_y3, slice_s[SLICE_W-1]);
      end else begin
        idx <= idx + 1'b1;
      end
    end
  end

  // Outputs derive directly from state and the held result registers.
  always_comb begin
    bus.start_ready = (state == IDLE);
    bus.res_valid   = (state == DONE);
    bus.busy        = (state != IDLE);
    bus.sum         = sum_r;
    bus.cout        = cout_r;
    bus.ov          = ov_r;
  end

endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
// tb/tb_nibble_serial_add_ctrl.sv - directed bench for nibble_serial_add_ctrl (optional NSAC_SUB_EN)
module tb_nibble_serial_add_ctrl;

  localparam int NIBBLES = 4;
  localparam int W = 4 * NIBBLES;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  nibble_serial_add_ctrl_if #(.NIBBLES(NIBBLES)) bus ();

  nibble_serial_add_ctrl #(.NIBBLES(NIBBLES)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present operands for one edge; the controller must be in IDLE.
  task automatic accept_op(input logic [W-1:0] av, input logic [W-1:0] bv, input logic subv);
    bus.a = av;
    bus.b = bv;
`ifdef NSAC_SUB_EN
    bus.sub = subv;
`else
    if (subv) $display("note: sub ignored in this build");
`endif
    bus.start_valid = 1'b1;
    @(posedge clk); #1;
    bus.start_valid = 1'b0;
  endtask

  task automatic test_reset();
    total++;
    if (bus.start_ready !== 1'b1 || bus.res_valid !== 1'b0 || bus.busy !== 1'b0) begin
      bad++;
      $display("FAIL reset_ctrl: ready=%b valid=%b busy=%b want 1 0 0", bus.start_ready, bus.res_valid, bus.busy);
    end
    total++;
    if (bus.sum !== 16'h0000 || bus.cout !== 1'b0 || bus.ov !== 1'b0) begin
      bad++;
      $display("FAIL reset_data: sum=%h cout=%b ov=%b want 0000 0 0", bus.sum, bus.cout, bus.ov);
    end
  endtask

  // Overflow into the sign bit plus exact latency measurement.
  task automatic test_pos_overflow();
    accept_op(16'h7FFF, 16'h0001, 1'b0);
    total++;
    if (bus.busy !== 1'b1 || bus.start_ready !== 1'b0) begin
      bad++;
      $display("FAIL pos_busy: busy=%b ready=%b want 1 0", bus.busy, bus.start_ready);
    end
    for (int k = 1; k <= NIBBLES; k++) begin
      @(posedge clk); #1;
      total++;
      if (bus.res_valid !== (k == NIBBLES)) begin
        bad++;
        $display("FAIL pos_latency: cycle %0d res_valid=%b want %b", k, bus.res_valid, (k == NIBBLES));
      end
    end
    total++;
    if (bus.sum !== 16'h8000 || bus.cout !== 1'b0 || bus.ov !== 1'b1) begin
      bad++;
      $display("FAIL pos_result: sum=%h cout=%b ov=%b want 8000 0 1", bus.sum, bus.cout, bus.ov);
    end
    bus.res_ready = 1'b1;
    @(posedge clk); #1;
    bus.res_ready = 1'b0;
    total++;
    if (bus.res_valid !== 1'b0 || bus.start_ready !== 1'b1 || bus.sum !== 16'h8000) begin
      bad++;
      $display("FAIL pos_release: valid=%b ready=%b sum=%h want 0 1 8000", bus.res_valid, bus.start_ready, bus.sum);
    end
  endtask

  // Generic directed operation with bounded wait for the result.
  task automatic test_vector(input string name, input logic [W-1:0] av, input logic [W-1:0] bv,
                             input logic subv, input logic [W-1:0] es, input logic ec, input logic eo);
    int n;
    accept_op(av, bv, subv);
    n = 0;
    while (bus.res_valid !== 1'b1 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    total++;
    if (n != NIBBLES) begin
      bad++;
      $display("FAIL %s_latency: cycles=%0d want %0d", name, n, NIBBLES);
    end
    total++;
    if (bus.sum !== es || bus.cout !== ec || bus.ov !== eo) begin
      bad++;
      $display("FAIL %s_result: sum=%h cout=%b ov=%b want %h %b %b", name, bus.sum, bus.cout, bus.ov, es, ec, eo);
    end
    bus.res_ready = 1'b1;
    @(posedge clk); #1;
    bus.res_ready = 1'b0;
  endtask

  // Result held under backpressure; a request during RUN/DONE waits for the handshake.
  task automatic test_backpressure();
    accept_op(16'h1234, 16'h1111, 1'b0);
    bus.a = 16'hAAAA;
    bus.b = 16'h5555;
    bus.start_valid = 1'b1;
    for (int k = 1; k <= NIBBLES; k++) begin
      total++;
      if (bus.start_ready !== 1'b0) begin
        bad++;
        $display("FAIL bp_run_ready: cycle %0d start_ready=%b want 0", k, bus.start_ready);
      end
      @(posedge clk); #1;
    end
    for (int k = 0; k < 3; k++) begin
      total++;
      if (bus.res_valid !== 1'b1 || bus.sum !== 16'h2345 || bus.start_ready !== 1'b0
          || bus.cout !== 1'b0 || bus.ov !== 1'b0) begin
        bad++;
        $display("FAIL bp_hold: cycle %0d valid=%b sum=%h ready=%b cout=%b ov=%b want 1 2345 0 0 0",
                 k, bus.res_valid, bus.sum, bus.start_ready, bus.cout, bus.ov);
      end
      @(posedge clk); #1;
    end
    bus.res_ready = 1'b1;
    @(posedge clk); #1;
    bus.res_ready = 1'b0;
    total++;
    if (bus.busy !== 1'b0 || bus.res_valid !== 1'b0 || bus.sum !== 16'h2345) begin
      bad++;
      $display("FAIL bp_handshake: busy=%b valid=%b sum=%h want 0 0 2345", bus.busy, bus.res_valid, bus.sum);
    end
    @(posedge clk); #1;
    bus.start_valid = 1'b0;
    total++;
    if (bus.busy !== 1'b1) begin
      bad++;
      $display("FAIL bp_second_accept: busy=%b want 1", bus.busy);
    end
    for (int k = 0; k < NIBBLES; k++) begin
      @(posedge clk); #1;
    end
    total++;
    if (bus.res_valid !== 1'b1 || bus.sum !== 16'hFFFF || bus.cout !== 1'b0 || bus.ov !== 1'b0) begin
      bad++;
      $display("FAIL bp_second_result: valid=%b sum=%h cout=%b ov=%b want 1 ffff 0 0",
               bus.res_valid, bus.sum, bus.cout, bus.ov);
    end
    bus.res_ready = 1'b1;
    @(posedge clk); #1;
    bus.res_ready = 1'b0;
  endtask

  // Reset at idx=2 aborts the operation; a fresh add then works.
  task automatic test_reset_mid_run();
    accept_op(16'h1111, 16'h2222, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    total++;
    if (bus.sum !== 16'h0000 || bus.cout !== 1'b0 || bus.ov !== 1'b0 || bus.res_valid !== 1'b0
        || bus.busy !== 1'b0 || bus.start_ready !== 1'b1) begin
      bad++;
      $display("FAIL midrun_reset: sum=%h cout=%b ov=%b valid=%b busy=%b ready=%b want 0000 0 0 0 0 1",
               bus.sum, bus.cout, bus.ov, bus.res_valid, bus.busy, bus.start_ready);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    for (int k = 0; k < NIBBLES + 1; k++) begin
      @(posedge clk); #1;
      total++;
      if (bus.res_valid !== 1'b0) begin
        bad++;
        $display("FAIL midrun_no_result: cycle %0d res_valid=%b want 0", k, bus.res_valid);
      end
    end
    test_vector("after_reset", 16'h0003, 16'h0004, 1'b0, 16'h0007, 1'b0, 1'b0);
  endtask

  initial begin
    total = 0;
    bad = 0;
    rst = 1'b1;
    bus.start_valid = 1'b0;
    bus.res_ready = 1'b0;
    bus.a = '0;
    bus.b = '0;
`ifdef NSAC_SUB_EN
    bus.sub = 1'b0;
`endif
    #12;
    test_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    test_pos_overflow();
    test_vector("unsigned_wrap", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
    test_vector("neg_overflow", 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1);
    test_vector("plain", 16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0);
    test_backpressure();
    test_reset_mid_run();
`ifdef NSAC_SUB_EN
    test_vector("sub_borrow", 16'h0000, 16'h0001, 1'b1, 16'hFFFF, 1'b0, 1'b0);
    test_vector("sub_overflow", 16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1);
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
